fetch_pipe_ctrl: RTL

FETCH_PIPE_CTRL -- requirements
Module: fetch_pipe_ctrl

---
 rtl/fetch_pipe_ctrl_pkg.sv | 33 +++
 rtl/fetch_pipe_ctrl_ifid.sv | 42 ++++
 rtl/fetch_pipe_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pipe_ctrl_pkg.sv
// Shared types for the fetch pipeline controller: FSM states, IF/ID record,
// register-update opcodes and PC arithmetic helpers.
package fetch_pipe_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        IFID_KEEP  = 2'd0,
        IFID_LOAD  = 2'd1,
        IFID_FLUSH = 2'd2
    } ifid_op_e;

    typedef struct packed {
        word_t instr;
        word_t pc4;
        logic  valid;
    } ifid_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;
    localparam word_t PC_STEP   = 32'd4;

    // 32-bit add, so 32'hFFFF_FFFC wraps to 0.
    function automatic word_t next_pc(input word_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_pipe_ctrl_ifid.sv
// IF/ID pipeline register: keeps, loads {instr, pc+4, valid=1} or flushes
// to a NOP bubble as commanded by the fetch controller.
module ifid_reg
    import fetch_pipe_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  ifid_op_e op_i,
    input  word_t    instr_i,
    input  word_t    pc4_i,
    output word_t    instr_o,
    output word_t    pc4_o,
    output logic     valid_o
);

    ifid_t ifid_d;
    ifid_t ifid_q;

    always_comb begin
        // NOTE: default assignment first so every path drives ifid_d and no latch is inferred.
        ifid_d = ifid_q;
        case (op_i)
            IFID_LOAD:  ifid_d = '{instr: instr_i, pc4: pc4_i, valid: 1'b1};
            IFID_FLUSH: ifid_d = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
            default:    ifid_d = ifid_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
        if (!rst_n) begin
            ifid_q <= '0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign instr_o = ifid_q.instr;
    assign pc4_o   = ifid_q.pc4;
    assign valid_o = ifid_q.valid;

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Instruction-fetch controller: PC, imem req/ready handshake, stall/redirect
// handling and the IF/ID register. Optional stall counter: FETCH_STALL_CNT_EN.
module fetch_pipe_ctrl
    import fetch_pipe_ctrl_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter int    CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             pc_if_write_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_target_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_ready_i,
    input  logic [31:0]      imem_rdata_i,
    output logic [31:0]      instr_id_o,
    output logic [31:0]      pc4_id_o,
    output logic             valid_id_o,
    output logic             bubble_ex_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic  hold;
    logic  redirect;
    word_t target;

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        drain_addr_q, drain_addr_d;
    word_t        fetch_buf_q, fetch_buf_d;

    ifid_op_e ifid_op;
    word_t    ifid_instr;
    word_t    ifid_pc4;

    assign hold     = stall_i | ~pc_if_write_i;
    assign redirect = branch_taken_i | jump_i;
    assign target   = branch_taken_i ? branch_target_i : jump_target_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        fetch_buf_d  = fetch_buf_q;
        ifid_op      = IFID_KEEP;
        ifid_instr   = imem_rdata_i;
        ifid_pc4     = next_pc(pc_q);

        case (state_q)
            FETCH: begin
                if (imem_ready_i) begin
                    if (redirect) begin
                        pc_d    = target;
                        ifid_op = IFID_FLUSH;
                    end else if (hold) begin
                        fetch_buf_d = imem_rdata_i;
                        state_d     = HOLD;
                    end else begin
                        ifid_op = IFID_LOAD;
                        pc_d    = next_pc(pc_q);
                    end
                end else begin
                    if (redirect) begin
                        // The bus still owes a reply for pc_q; keep presenting it until it lands.
                        drain_addr_d = pc_q;
                        pc_d         = target;
                        ifid_op      = IFID_FLUSH;
                        state_d      = DRAIN;
                    end else if (!hold) begin
                        ifid_op = IFID_FLUSH;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_d        = target;
                    ifid_op     = IFID_FLUSH;
                    fetch_buf_d = NOP_INSTR;
                    state_d     = FETCH;
                end else if (!hold) begin
                    ifid_op    = IFID_LOAD;
                    ifid_instr = fetch_buf_q;
                    pc_d       = next_pc(pc_q);
                    state_d    = FETCH;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ready_i) begin
                    state_d = FETCH;
                end
            end

            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            fetch_buf_q  <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            fetch_buf_q  <= fetch_buf_d;
        end
    end

    // Request is suppressed combinationally during reset so an in-flight fetch is abandoned.
    assign imem_req_o  = rst_n & (state_q != HOLD);
    assign imem_addr_o = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign bubble_ex_o = hold & ~redirect;

    ifid_reg u_ifid_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .op_i    (ifid_op),
        .instr_i (ifid_instr),
        .pc4_i   (ifid_pc4),
        .instr_o (instr_id_o),
        .pc4_o   (pc4_id_o),
        .valid_o (valid_id_o)
    );

`ifdef FETCH_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bubble_ex_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
